// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
// Timing and mode controller for a digital-clock counter chain
// (seconds mod-60, minutes mod-60, hours).
//  - Divides clk down to a one-cycle seconds tick (sec_en) while running.
//  - Forwards counter carries (sec_oc -> min_en, min_oc -> hour_en) in RUN.
//  - Steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN on each mode press.
//    An inc press in a SET state bumps the selected field.
//  - Produces a blink phase for the field being set.
//
// Ports
//  clk       in   system clock, everything on posedge
//  rst       in   synchronous reset, active-high
//  btn_mode  in   mode button level (debounced, synchronous)
//  btn_inc   in   increment button level (debounced, synchronous)
//  sec_oc    in   seconds counter wrap pulse
//  min_oc    in   minutes counter wrap pulse
//  sec_en    out  seconds counter enable pulse
//  min_en    out  minutes counter enable pulse
//  hour_en   out  hours counter enable pulse
//  sec_clr   out  seconds counter clear pulse
//  mode      out  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//  blink     out  blink phase of the field being set, 0 in RUN
//
// Optional feature macro: AUTO_REPEAT_EN
//  When defined, holding btn_inc in a SET state auto-repeats the increment.
//  It fires once after REPEAT_DLY cycles, then every REPEAT_PER cycles.
//  The REPEAT_* parameters exist only in that build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module clock_set_ctrl #(
   parameter int CLK_DIV    = 50_000_000,
   parameter int BLINK_DIV  = 25_000_000
`ifdef AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DLY = 25_000_000,
   parameter int REPEAT_PER = 10_000_000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       sec_oc,
   input  logic       min_oc,
   output logic       sec_en,
   output logic       min_en,
   output logic       hour_en,
   output logic       sec_clr,
   output logic [1:0] mode,
   output logic       blink
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } state_t;

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   state_t          state;
   state_t          next_state;
   logic            btn_mode_q;
   logic            btn_inc_q;
   logic            mode_press;
   logic            inc_press;
   logic            inc_pulse;
   logic            run_steady;
   logic [PW-1:0]   presc_cnt;
   logic [PW-1:0]   presc_nxt;
   logic [BW-1:0]   blink_cnt;
   logic [BW-1:0]   blink_cnt_nxt;
   logic            blink_nxt;
   logic            sec_en_nxt;
   logic            min_en_nxt;
   logic            hour_en_nxt;
   logic            sec_clr_nxt;

`ifdef AUTO_REPEAT_EN
   localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PER - 1);

   logic            hold_armed;
   logic            rep_phase;
   logic [RW-1:0]   hold_cnt;
   logic            hold_active;
   logic            repeat_fire;
`endif

   // Edge detect both buttons against last cycle's sample and work out the
   // next mode. A mode press always wins, so an inc press arriving in the
   // same cycle is dropped. Inc only counts while a SET state is held steady.
   always_comb begin
      mode_press = btn_mode & ~btn_mode_q;
      inc_press  = btn_inc & ~btn_inc_q;
      next_state = state;
      if (mode_press) begin
         case (state)
            RUN:      next_state = SET_HOUR;
            SET_HOUR: next_state = SET_MIN;
            SET_MIN:  next_state = SET_SEC;
            default:  next_state = RUN;
         endcase
      end
      inc_pulse = inc_press && !mode_press && (state != RUN);
`ifdef AUTO_REPEAT_EN
      hold_active = hold_armed && btn_inc && !mode_press && (state != RUN);
      repeat_fire = hold_active &&
                    (rep_phase ? (hold_cnt == PER_MAX) : (hold_cnt == DLY_MAX));
      inc_pulse   = inc_pulse || repeat_fire;
`endif
   end

   // Next values for every registered output. The prescaler and carries
   // only work while RUN is both current and next. Entering RUN therefore
   // starts from a zero prescaler. A carry that lands on a mode change is
   // ignored. The blink counter runs only in SET states. Every SET-state
   // entry, including SET-to-SET steps, restarts it with blink high.
   always_comb begin
      run_steady    = (state == RUN) && (next_state == RUN);
      presc_nxt     = '0;
      sec_en_nxt    = 1'b0;
      min_en_nxt    = 1'b0;
      hour_en_nxt   = 1'b0;
      sec_clr_nxt   = 1'b0;
      blink_nxt     = 1'b0;
      blink_cnt_nxt = '0;

      if (run_steady) begin
         sec_en_nxt  = (presc_cnt == PRESC_MAX);
         presc_nxt   = (presc_cnt == PRESC_MAX) ? '0 : presc_cnt + 1'b1;
         min_en_nxt  = sec_oc;
         hour_en_nxt = min_oc;
      end

      if (next_state != RUN) begin
         if (next_state != state) begin
            blink_nxt = 1'b1;
         end else if (blink_cnt == BLINK_MAX) begin
            blink_nxt = ~blink;
         end else begin
            blink_nxt     = blink;
            blink_cnt_nxt = blink_cnt + 1'b1;
         end
      end

      if (inc_pulse) begin
         case (state)
            SET_HOUR: hour_en_nxt = 1'b1;
            SET_MIN:  min_en_nxt  = 1'b1;
            SET_SEC:  sec_clr_nxt = 1'b1;
            default:  ;
         endcase
      end
   end

   // State register, button history and all registered outputs. Reset
   // zeroes everything, so no pulse can appear in the cycle after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         btn_mode_q <= 1'b0;
         btn_inc_q  <= 1'b0;
         presc_cnt  <= '0;
         blink_cnt  <= '0;
         blink      <= 1'b0;
         sec_en     <= 1'b0;
         min_en     <= 1'b0;
         hour_en    <= 1'b0;
         sec_clr    <= 1'b0;
      end else begin
         state      <= next_state;
         btn_mode_q <= btn_mode;
         btn_inc_q  <= btn_inc;
         presc_cnt  <= presc_nxt;
         blink_cnt  <= blink_cnt_nxt;
         blink      <= blink_nxt;
         sec_en     <= sec_en_nxt;
         min_en     <= min_en_nxt;
         hour_en    <= hour_en_nxt;
         sec_clr    <= sec_clr_nxt;
      end
   end

`ifdef AUTO_REPEAT_EN
   // Hold tracking for auto-repeat. It is armed only by an accepted inc
   // press in a SET state. This stops a button still held across a mode
   // change from restarting the repeat in the new field. After the first
   // delay expires, rep_phase switches the interval to the repeat period.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_armed <= 1'b0;
         rep_phase  <= 1'b0;
         hold_cnt   <= '0;
      end else if (inc_press && !mode_press && (state != RUN)) begin
         hold_armed <= 1'b1;
         rep_phase  <= 1'b0;
         hold_cnt   <= '0;
      end else if (!hold_active) begin
         hold_armed <= 1'b0;
         rep_phase  <= 1'b0;
         hold_cnt   <= '0;
      end else if (repeat_fire) begin
         rep_phase  <= 1'b1;
         hold_cnt   <= '0;
      end else begin
         hold_cnt   <= hold_cnt + 1'b1;
      end
   end
`endif

   assign mode = state;

endmodule
